// File: rtl/bw_mult_arbiter_pkg.sv
// Shared defaults and helpers for the round-robin arbitrated Baugh-Wooley multiplier.
package bw_mult_arbiter_pkg;

  localparam int N_DEF    = 16;
  localparam int NREQ_DEF = 4;

  // Q(N-1) saturation limits at the default operand width
  localparam logic [N_DEF-1:0] Q_MAX_DEF = {1'b0, {(N_DEF-1){1'b1}}};
  localparam logic [N_DEF-1:0] Q_MIN_DEF = {1'b1, {(N_DEF-1){1'b0}}};

  // Requester index width; a single requester still gets a 1-bit id
  function automatic int calc_iw(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // Largest positive Q(n-1) value, zero-extended to 64 bits
  function automatic logic [63:0] q_pos_sat(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/bw_mult_arbiter_mult.sv
// Combinational N x N signed multiplier, modified Baugh-Wooley array.
module bw_mult #(
  parameter int N = 16
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  logic [2*N-1:0] acc;
  logic [N-1:0]   row;

  // Sign-row terms are complemented; the 2^N and 2^(2N-1) constants restore the sign.
  always_comb begin
    acc          = '0;
    row          = '0;
    acc[N]       = 1'b1;
    acc[2*N-1]   = 1'b1;
    for (int j = 0; j < N; j++) begin
      if (j < N - 1)
        row = {~(a[N-1] & b[j]), a[N-2:0] & {(N-1){b[j]}}};
      else
        row = {a[N-1] & b[N-1], ~(a[N-2:0] & {(N-1){b[N-1]}})};
      acc = acc + ({{N{1'b0}}, row} << j);
    end
  end

  assign p = acc;

endmodule

// File: rtl/bw_mult_arbiter.sv
// Round-robin arbiter feeding a two-stage signed multiply pipeline with Q(N-1) output.
module bw_mult_arbiter
  import bw_mult_arbiter_pkg::*;
#(
  parameter  int N    = N_DEF,
  parameter  int NREQ = NREQ_DEF,
  localparam int IW   = calc_iw(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2*N-1:0]    rsp_p,
  output logic [N-1:0]      rsp_q,
  output logic [IW-1:0]     rsp_id
);

  localparam logic [63:0]  Q_MAX_W = q_pos_sat(N);
  localparam logic [N-1:0] Q_MAX   = Q_MAX_W[N-1:0];
  localparam logic [N-1:0] Q_MIN   = ~Q_MAX;

  logic [IW-1:0]  ptr;
  logic           gnt_any;
  logic [IW-1:0]  gnt_idx;
  logic [IW-1:0]  idx_s;
  int             idx;
  logic [N-1:0]   gnt_a, gnt_b;
  logic           load_p1, load_p2;

  logic           vld_p1;
  logic signed [N-1:0] a_p1, b_p1;
  logic [IW-1:0]  id_p1;
  logic [2*N-1:0] mult_p;

  logic           vld_p2;
  logic signed [2*N-1:0] p_p2;
  logic signed [N-1:0]   q_p2;
  logic [IW-1:0]  id_p2;

  // Only a*b = (-2^(N-1))^2 overflows the Q(N-1) window; clamp symmetrically anyway.
  function automatic logic [N-1:0] sat_q(input logic [2*N-1:0] p);
    if (p[2*N-1] != p[2*N-2])
      return p[2*N-1] ? Q_MIN : Q_MAX;
    return p[2*N-2:N-1];
  endfunction

  // Lowest offset from ptr wins, so scan offsets high to low and keep the last hit.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    idx_s   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx   = (int'(ptr) + k) % NREQ;
      idx_s = IW'(idx);
      if (req_valid[idx_s]) begin
        gnt_any = 1'b1;
        gnt_idx = idx_s;
      end
    end
  end

  assign load_p2   = !vld_p2 || rsp_ready;
  assign load_p1   = !vld_p1 || load_p2;
  assign req_ready = (rst_n && gnt_any && load_p1) ? (NREQ'(1) << gnt_idx) : '0;
  assign gnt_a     = req_a[gnt_idx*N +: N];
  assign gnt_b     = req_b[gnt_idx*N +: N];

  bw_mult #(.N(N)) u_mult (
    .a (a_p1),
    .b (b_p1),
    .p (mult_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      vld_p1 <= 1'b0;
      a_p1   <= '0;
      b_p1   <= '0;
      id_p1  <= '0;
      vld_p2 <= 1'b0;
      p_p2   <= '0;
      q_p2   <= '0;
      id_p2  <= '0;
    end else begin
      // Stage 2: product register, held while the consumer stalls
      if (load_p2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          p_p2  <= mult_p;
          q_p2  <= sat_q(mult_p);
          id_p2 <= id_p1;
        end
      end
      // Stage 1: granted operands
      if (load_p1) begin
        vld_p1 <= gnt_any;
        if (gnt_any) begin
          a_p1  <= gnt_a;
          b_p1  <= gnt_b;
          id_p1 <= gnt_idx;
          ptr   <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
    end
  end

  assign rsp_valid = vld_p2;
  assign rsp_p     = p_p2;
  assign rsp_q     = q_p2;
  assign rsp_id    = id_p2;

endmodule

// File: tb/tb_bw_mult_arbiter.sv
// Randomised bench for bw_mult_arbiter against an arithmetic reference model.
module tb_bw_mult_arbiter;

  localparam int N    = 16;
  localparam int NREQ = 4;
  localparam int PW   = 2 * N;
  localparam int IW   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a, req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [PW-1:0]     rsp_p;
  logic [N-1:0]      rsp_q;
  logic [IW-1:0]     rsp_id;

  always #5 clk = ~clk;

  bw_mult_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_q     (rsp_q),
    .rsp_id    (rsp_id)
  );

  int checks = 0;
  int failures = 0;

  bit           rv [NREQ];
  logic [N-1:0] ra [NREQ];
  logic [N-1:0] rb [NREQ];
  int           mode;
  logic [NREQ-1:0] last_rdy;

  // Reference: arbitration pointer, two pipeline slots, per-requester result queues
  int            m_ptr;
  bit            m_s1v, m_s2v;
  int            m_s1_id, m_s2_id;
  logic [PW-1:0] m_s1_p, m_s2_p;
  logic [N-1:0]  m_s1_q, m_s2_q;
  logic [PW-1:0] sb [NREQ][$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] ref_p(input logic [N-1:0] a, input logic [N-1:0] b);
    longint x;
    x = longint'($signed(a)) * longint'($signed(b));
    return x[PW-1:0];
  endfunction

  function automatic logic [N-1:0] ref_q(input logic [N-1:0] a, input logic [N-1:0] b);
    longint x, q, qmax;
    x    = longint'($signed(a)) * longint'($signed(b));
    q    = x >>> (N - 1);
    qmax = (longint'(1) << (N - 1)) - 1;
    if (q > qmax) q = qmax;
    return q[N-1:0];
  endfunction

  function automatic int pick();
    for (int k = 0; k < NREQ; k++)
      if (rv[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [N-1:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return N'($urandom);
    endcase
  endfunction

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]       = rv[i];
      req_a[i*N +: N]    = ra[i];
      req_b[i*N +: N]    = rb[i];
    end
  endtask

  task automatic refill();
    if (mode == 1) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++)
        if (!rv[i] && $urandom_range(0, 9) < 4) begin
          rv[i] = 1'b1; ra[i] = rand_op(); rb[i] = rand_op();
        end
    end else if (mode == 2) begin
      for (int i = 0; i < NREQ; i++)
        if (!rv[i]) begin
          rv[i] = 1'b1; ra[i] = N'($urandom); rb[i] = N'($urandom);
        end
    end
    apply();
  endtask

  task automatic model_reset();
    m_ptr = 0; m_s1v = 1'b0; m_s2v = 1'b0;
    for (int i = 0; i < NREQ; i++) sb[i].delete();
  endtask

  // One cycle: compare at the falling edge, then advance the model over the rising edge.
  task automatic step();
    logic [NREQ-1:0] exp_rdy;
    logic [PW-1:0]   sb_head;
    bit              s1_load, s2_load;
    int              g;
    #4;
    s2_load = !m_s2v || rsp_ready;
    s1_load = !m_s1v || s2_load;
    g = s1_load ? pick() : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    last_rdy = req_ready;
    check("req_ready", req_ready, exp_rdy);
    check("rsp_valid", rsp_valid, m_s2v);
    if (m_s2v) begin
      check("rsp_p", rsp_p, m_s2_p);
      check("rsp_q", rsp_q, m_s2_q);
      check("rsp_id", rsp_id, m_s2_id);
      if (rsp_ready) begin
        if (sb[m_s2_id].size() == 0) check("sb_underflow", 1'b1, 1'b0);
        else begin
          sb_head = sb[m_s2_id].pop_front();
          check("sb_order", rsp_p, sb_head);
        end
      end
    end
    @(posedge clk);
    if (s2_load) begin
      m_s2v = m_s1v;
      if (m_s1v) begin m_s2_p = m_s1_p; m_s2_q = m_s1_q; m_s2_id = m_s1_id; end
    end
    if (s1_load) begin
      m_s1v = (g >= 0);
      if (g >= 0) begin
        m_s1_id = g;
        m_s1_p  = ref_p(ra[g], rb[g]);
        m_s1_q  = ref_q(ra[g], rb[g]);
        sb[g].push_back(m_s1_p);
        m_ptr   = (g + 1) % NREQ;
        rv[g]   = 1'b0;
      end
    end
    #1;
    refill();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt, busy, total;
    rst_n = 1'b0; rsp_ready = 1'b0; mode = 0; last_rdy = '0;
    model_reset();
    for (int i = 0; i < NREQ; i++) begin
      rv[i] = 1'b1; ra[i] = N'(i + 1); rb[i] = N'(i + 2);
    end
    apply();
    #12;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_p", rsp_p, 0);
    check("rst_rsp_q", rsp_q, 0);
    check("rst_rsp_id", rsp_id, 0);
    for (int i = 0; i < NREQ; i++) rv[i] = 1'b0;
    apply();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Continuous demand: strict rotation and one response per cycle
    mode = 2; rsp_ready = 1'b1; refill();
    for (int c = 0; c < 8; c++) begin
      step();
      check("rr_grant", last_rdy, 4'b0001 << (c % 4));
      if (c >= 1) check("rr_rsp_valid", rsp_valid, 1'b1);
    end
    mode = 0;
    for (int c = 0; c < 7; c++) step();

    // Single request: 3 * -5 from requester 2, two-cycle latency
    rv[2] = 1'b1; ra[2] = 16'd3; rb[2] = 16'hFFFB; apply();
    step();
    check("t1_grant", last_rdy, 4'b0100);
    check("t1_not_yet", rsp_valid, 1'b0);
    step();
    check("t1_valid", rsp_valid, 1'b1);
    check("t1_p", rsp_p, 32'hFFFF_FFF1);
    check("t1_q", rsp_q, 16'hFFFF);
    check("t1_id", rsp_id, 2);
    step();

    // Saturation corner and a plain Q15 square
    rv[0] = 1'b1; ra[0] = 16'h8000; rb[0] = 16'h8000;
    rv[1] = 1'b1; ra[1] = 16'h4000; rb[1] = 16'h4000;
    apply();
    step(); step();
    check("sat_p", rsp_p, 32'h4000_0000);
    check("sat_q", rsp_q, 16'h7FFF);
    check("sat_id", rsp_id, 0);
    step();
    check("half_p", rsp_p, 32'h1000_0000);
    check("half_q", rsp_q, 16'h2000);
    step(); step();

    // Backpressure with three pending requests
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (i != 2) begin rv[i] = 1'b1; ra[i] = rand_op(); rb[i] = rand_op(); end
    apply();
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (last_rdy != '0) cnt++;
    end
    check("bp_accepts_le2", cnt <= 2, 1'b1);
    check("bp_rsp_held", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) step();
    check("bp_drained", rsp_valid, 1'b0);

    // Random traffic and random consumer stalls
    mode = 1;
    for (int c = 0; c < 400; c++) step();

    mode = 0; rsp_ready = 1'b1;
    busy = 1;
    for (int c = 0; c < 60 && busy != 0; c++) begin
      busy = int'(m_s1v) + int'(m_s2v);
      for (int i = 0; i < NREQ; i++) busy += int'(rv[i]);
      if (busy != 0) step();
    end
    check("drain_done", busy, 0);

    // Reset with both stages full
    rsp_ready = 1'b0;
    for (int i = 1; i < NREQ; i++) begin rv[i] = 1'b1; ra[i] = rand_op(); rb[i] = rand_op(); end
    apply();
    step(); step(); step();
    check("r37_full", rsp_valid, 1'b1);
    #1; rst_n = 1'b0; #1;
    check("r37_rsp_valid", rsp_valid, 1'b0);
    check("r37_rsp_p", rsp_p, 0);
    check("r37_rsp_id", rsp_id, 0);
    check("r37_req_ready", req_ready, 0);
    model_reset();
    for (int i = 0; i < NREQ; i++) rv[i] = 1'b0;
    rv[1] = 1'b1; ra[1] = rand_op(); rb[1] = rand_op();
    rv[3] = 1'b1; ra[3] = rand_op(); rb[3] = rand_op();
    apply();
    @(posedge clk); #1;
    rst_n = 1'b1; rsp_ready = 1'b1;
    step();
    check("r37_first_grant", last_rdy, 4'b0010);
    for (int c = 0; c < 6; c++) step();

    total = 0;
    for (int i = 0; i < NREQ; i++) total += sb[i].size();
    check("final_sb_empty", total, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
